ram_1r1w_sync: RTL and testbench
================================

Name: ram_1r1w_sync

Overview:
- Parametrised single-clock, one-read/one-write memory. Successor to the fixed-size combinational-read RAM macros.
- Adds a registered read with a configurable pipeline depth, a read-valid flag, per-lane write masks and write-to-read bypass on address collision.
- Sits under the LSU/ROB/predictor tables as the common storage primitive. Memory-compiler macros slot in behind the same interface.

Parameters:
- DEPTH, 64, number of entries; any value >= 2, not necessarily a power of two.
- WIDTH, 32, bits per entry.
- MASK_GRAN, 8, bits per write-mask lane; WIDTH must be a multiple of MASK_GRAN.
- READ_LATENCY, 1, cycles from R0_en to R0_data; legal values 1 or 2.
- BYPASS, 1, 1 = write-first on same-address collision, 0 = read-old.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- R0_en  in  1  read request this cycle.
- R0_addr  in  AW  read address; AW = max(1, $clog2(DEPTH)).
- R0_data  out  WIDTH  read data, aligned with R0_valid.
- R0_valid  out  1  R0_data holds the result of a read issued READ_LATENCY cycles earlier.
- W0_en  in  1  write request this cycle.
- W0_addr  in  AW  write address.
- W0_data  in  WIDTH  write data.
- W0_mask  in  WIDTH/MASK_GRAN  per-lane write enable; lane i covers bits [i*MASK_GRAN +: MASK_GRAN].
- init_busy  out  1  high while the clear sweep runs (see Optional Feature).

Behaviour:
- Reset (reset_n low, asynchronous):
  - R0_valid = 0, R0_data = 0, all pipeline stages = 0, init_busy = 0 (without macro).
  - The storage array itself is not reset.
- Write:
  - At the rising edge with W0_en=1, lane i of Memory[W0_addr] is updated only where W0_mask[i]=1.
  - W0_en=1 with mask all-zero is a no-op.
- Read, READ_LATENCY=1:
  - R0_en=1 at edge N gives R0_data/R0_valid at edge N+1.
  - R0_en=0 gives R0_valid=0 next cycle; R0_data holds its last value (no X).
- Read, READ_LATENCY=2:
  - An extra output register stage follows; data and valid are delayed together.
  - Fully pipelined: back-to-back reads every cycle are allowed.
- Collision (R0_en & W0_en & equal address, same cycle):
  - BYPASS=1: masked lanes return W0_data and unmasked lanes return the old contents.
  - BYPASS=0: the old contents are returned.
  - Write-then-read on the next cycle always returns the new data.
- Out-of-range address (addr >= DEPTH, non-power-of-two DEPTH):
  - The write is dropped.
  - The read returns all-zero with R0_valid=1.
- Reset asserted mid-operation: in-flight reads are discarded (valid drops to 0 immediately). Memory contents are undefined afterwards.
- No X ever propagates to R0_data after reset.

Optional Feature:
- Macro: RAM_CLEAR_ON_RESET_EN.
- With the macro:
  - A 2-state FSM (IDLE, CLEAR) with an AW-bit sweep counter.
  - Reset puts the FSM in CLEAR with counter = 0 and init_busy=1.
  - Each cycle, Memory[counter] is written with 0 and the counter increments.
  - After address DEPTH-1 the FSM goes to IDLE and init_busy=0; the sweep takes exactly DEPTH cycles after reset release.
  - While in CLEAR, R0_en and W0_en are ignored and R0_valid stays 0.
- Without the macro: no FSM and no counter; init_busy is tied 0 and memory powers up undefined.

Decomposition:
- Package ram_pkg:
  - function ram_addr_w(depth) returning max(1, $clog2(depth));
  - enum ram_clear_state_e {RAM_IDLE, RAM_CLEAR};
  - localparam RAM_MAX_READ_LATENCY = 2.
- Sub-module ram_read_pipe:
  - READ_LATENCY-stage data+valid register chain with asynchronous active-low reset.
  - Instantiated once; keeps array inference clean in the top module.

Test Plan:
- Reset, then write 0xDEADBEEF to address 5 with mask 4'hF, then read address 5. Expect R0_valid=1 and R0_data=0xDEADBEEF at 1 cycle (LAT=1) and at 2 cycles (LAT=2).
- Address 3 holds 0x11223344. Write 0xAABBCCDD with mask 4'b0101, then read. Expect 0x11BB33DD.
- Same-cycle collision on address 7: old=0x0, write 0xFFFFFFFF with mask 4'b0011.
  - BYPASS=1: expect 0x0000FFFF.
  - BYPASS=0: expect 0x00000000.
- DEPTH=48: write 0x12345678 to address 50, then read 50 and 50-32=18. Expect 0x00000000 on both reads and address 18 unchanged.
- Back-to-back reads of addresses 0..15 every cycle with LAT=2. Expect 16 consecutive valid beats, in order, with no gaps; R0_en low expects R0_valid=0.
- RAM_CLEAR_ON_RESET_EN, DEPTH=64:
  - Expect init_busy high for exactly 64 cycles after reset release, with reads ignored during that window.
  - Then every address reads 0.
  - Re-asserting reset at sweep cycle 20 restarts the sweep from address 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_1r1w_sync storage primitive.
package ram_pkg;

    localparam int unsigned RAM_MAX_READ_LATENCY = 2;

    typedef enum logic {
        RAM_IDLE  = 1'b0,
        RAM_CLEAR = 1'b1
    } ram_clear_state_e;

    // Address width for a given depth, never narrower than one bit.
    function automatic int unsigned ram_addr_w(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Read-data pipeline: LATENCY stages of data+valid. Data only advances with
// valid, so the output holds the last returned word between reads.
module ram_read_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]            valid_q, valid_d;
    logic [LATENCY-1:0][WIDTH-1:0] data_q, data_d;

    // Next-stage values: valid always shifts, data only moves when valid.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        valid_d[0] = in_valid;
        if (in_valid) begin
            data_d[0] = in_data;
        end
        for (int i = 1; i < int'(LATENCY); i++) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    // Stage registers; reset drops every in-flight read immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/ram_1r1w_sync.sv
// Single-clock 1R1W memory with registered read, lane write masks and
// optional write-first bypass. Define RAM_CLEAR_ON_RESET_EN to zero the
// array with a sweep after every reset.
module ram_1r1w_sync
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned MASK_GRAN    = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BYPASS       = 1
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            R0_en,
    input  logic [ram_addr_w(DEPTH)-1:0]    R0_addr,
    output logic [WIDTH-1:0]                R0_data,
    output logic                            R0_valid,
    input  logic                            W0_en,
    input  logic [ram_addr_w(DEPTH)-1:0]    W0_addr,
    input  logic [WIDTH-1:0]                W0_data,
    input  logic [WIDTH/MASK_GRAN-1:0]      W0_mask,
    output logic                            init_busy
);

    localparam int unsigned AW    = ram_addr_w(DEPTH);
    localparam int unsigned LANES = WIDTH / MASK_GRAN;
    localparam int unsigned LAT   = (READ_LATENCY < 1) ? 1 :
                                    ((READ_LATENCY > RAM_MAX_READ_LATENCY) ?
                                     RAM_MAX_READ_LATENCY : READ_LATENCY);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             busy;
    logic             rd_in_range_c;
    logic             wr_in_range_c;
    logic             rd_en_c;
    logic [WIDTH-1:0] rd_data_c;
    logic             wr_en_c;
    logic [AW-1:0]    wr_addr_c;
    logic [WIDTH-1:0] wr_data_c;
    logic [LANES-1:0] wr_mask_c;

`ifdef RAM_CLEAR_ON_RESET_EN
    ram_clear_state_e state_q, state_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic             busy_q, busy_d;

    // Clear sweep: walk every address once, then hand the array to users.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == RAM_CLEAR) begin
            if (32'(clr_cnt_q) == DEPTH - 1) begin
                state_d   = RAM_IDLE;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + AW'(1);
            end
        end
        busy_d = (state_d == RAM_CLEAR);
    end

    // Sweep state registers; reset restarts the sweep from address 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RAM_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    assign init_busy     = busy;
    assign rd_in_range_c = 32'(R0_addr) < DEPTH;
    assign wr_in_range_c = 32'(W0_addr) < DEPTH;
    assign rd_en_c       = R0_en & ~busy;

    // Write port select: user write, or the clear sweep while busy.
    always_comb begin
        wr_en_c   = W0_en & ~busy & wr_in_range_c;
        wr_addr_c = W0_addr;
        wr_data_c = W0_data;
        wr_mask_c = W0_mask;
`ifdef RAM_CLEAR_ON_RESET_EN
        if (busy) begin
            wr_en_c   = 1'b1;
            wr_addr_c = clr_cnt_q;
            wr_data_c = '0;
            wr_mask_c = '1;
        end
`endif
    end

    // Storage array, lane-masked writes; intentionally not reset.
    always_ff @(posedge clock) begin
        if (wr_en_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (wr_mask_c[i]) begin
                    mem_q[wr_addr_c][i*MASK_GRAN +: MASK_GRAN] <=
                        wr_data_c[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Read word: zero when out of range, masked write lanes forwarded on collision.
    always_comb begin
        rd_data_c = '0;
        if (rd_in_range_c) begin
            rd_data_c = mem_q[R0_addr];
            if ((BYPASS != 0) && W0_en && !busy && (W0_addr == R0_addr)) begin
                for (int i = 0; i < int'(LANES); i++) begin
                    if (W0_mask[i]) begin
                        rd_data_c[i*MASK_GRAN +: MASK_GRAN] =
                            W0_data[i*MASK_GRAN +: MASK_GRAN];
                    end
                end
            end
        end
    end

    ram_read_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (LAT)
    ) u_read_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (rd_en_c),
        .in_data   (rd_data_c),
        .out_valid (R0_valid),
        .out_data  (R0_data)
    );

endmodule

// File: tb/tb_ram_1r1w_sync.sv
// Bench for ram_1r1w_sync: two instances sharing stimulus.
//   dut_a: DEPTH=48, READ_LATENCY=1, BYPASS=1
//   dut_b: DEPTH=64, READ_LATENCY=2, BYPASS=0
module tb_ram_1r1w_sync;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
    } exp_t;

    typedef struct packed {
        logic        re;
        logic [5:0]  ra;
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

`ifdef RAM_CLEAR_ON_RESET_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        r_en;
    logic [5:0]  r_addr;
    logic        w_en;
    logic [5:0]  w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_mask;
    logic [31:0] a_data, b_data;
    logic        a_valid, b_valid, a_busy, b_busy;

    always #5 clock = ~clock;

    ram_1r1w_sync #(.DEPTH(48), .WIDTH(32), .MASK_GRAN(8), .READ_LATENCY(1), .BYPASS(1)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .R0_en(r_en), .R0_addr(r_addr), .R0_data(a_data), .R0_valid(a_valid),
        .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
        .init_busy(a_busy)
    );

    ram_1r1w_sync #(.DEPTH(64), .WIDTH(32), .MASK_GRAN(8), .READ_LATENCY(2), .BYPASS(0)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .R0_en(r_en), .R0_addr(r_addr), .R0_data(b_data), .R0_valid(b_valid),
        .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
        .init_busy(b_busy)
    );

    int          n_cmp;
    int          n_bad;
    int          step_no;
    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] last_a, last_b;
    logic [31:0] ma[64];
    logic [31:0] mb[64];
    vec_t        tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @step %0d actual=%h required=%h", name, step_no, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wm);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (wm[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    // Expected read word for one instance, taken before this cycle's write lands.
    function automatic logic [31:0] model_rd(input bit is_a, input logic [5:0] ra,
                                             input logic we, input logic [5:0] wa,
                                             input logic [31:0] wd, input logic [3:0] wm);
        if (is_a) begin
            if (ra >= 6'd48) return 32'h0;
            if (we && (wa == ra)) return merge(ma[ra], wd, wm);
            return ma[ra];
        end
        return mb[ra];
    endfunction

    function automatic vec_t mkv(input logic re, input logic [5:0] ra, input logic we,
                                 input logic [5:0] wa, input logic [31:0] wd,
                                 input logic [3:0] wm, input logic [31:0] ea,
                                 input logic [31:0] eb);
        vec_t v;
        v.re = re; v.ra = ra; v.we = we; v.wa = wa; v.wd = wd; v.wm = wm;
        v.ea = ea; v.eb = eb;
        return v;
    endfunction

    function automatic void sb_restart();
        exp_t e;
        qa.delete();
        qb.delete();
        last_a = 32'h0;
        last_b = 32'h0;
        e = '0;
        qb.push_back(e);
    endfunction

    // One cycle: drive, push expectations, update model, compare after the edge.
    task automatic step(input logic re, input logic [5:0] ra, input logic we,
                        input logic [5:0] wa, input logic [31:0] wd, input logic [3:0] wm,
                        input logic [31:0] ea, input logic [31:0] eb);
        exp_t e;
        @(negedge clock);
        r_en = re; r_addr = ra; w_en = we; w_addr = wa; w_data = wd; w_mask = wm;
        if (re) begin
            last_a = ea;
            last_b = eb;
        end
        e.v = re; e.d = last_a; qa.push_back(e);
        e.v = re; e.d = last_b; qb.push_back(e);
        if (we) begin
            if (wa < 6'd48) ma[wa] = merge(ma[wa], wd, wm);
            mb[wa] = merge(mb[wa], wd, wm);
        end
        @(posedge clock);
        #1;
        step_no++;
        if (qa.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_a @step %0d actual=empty required=entry", step_no);
        end else begin
            e = qa.pop_front();
            chk("a_valid", 32'(a_valid), 32'(e.v));
            chk("a_data", a_data, e.d);
        end
        if (qb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_b @step %0d actual=empty required=entry", step_no);
        end else begin
            e = qb.pop_front();
            chk("b_valid", 32'(b_valid), 32'(e.v));
            chk("b_data", b_data, e.d);
        end
        chk("a_busy", 32'(a_busy), 32'h0);
        chk("b_busy", 32'(b_busy), 32'h0);
    endtask

    task automatic step_m(input logic re, input logic [5:0] ra, input logic we,
                          input logic [5:0] wa, input logic [31:0] wd, input logic [3:0] wm);
        step(re, ra, we, wa, wd, wm, model_rd(1'b1, ra, we, wa, wd, wm),
             model_rd(1'b0, ra, we, wa, wd, wm));
    endtask

    // Assert reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(negedge clock);
        r_en = 1'b0; w_en = 1'b0; reset_n = 1'b0;
        #1;
        chk("rst_a_valid", 32'(a_valid), 32'h0);
        chk("rst_b_valid", 32'(b_valid), 32'h0);
        repeat (2) @(negedge clock);
        chk("rst_a_data", a_data, 32'h0);
        chk("rst_b_data", b_data, 32'h0);
        chk("rst_a_busy", 32'(a_busy), 32'(BUSY_RST));
        chk("rst_b_busy", 32'(b_busy), 32'(BUSY_RST));
        reset_n = 1'b1;
        sb_restart();
    endtask

`ifdef RAM_CLEAR_ON_RESET_EN
    // Called at the negedge of reset release; stop_at > 0 abandons the sweep early.
    task automatic clear_sweep(input int stop_at);
        for (int k = 1; k <= 64; k++) begin
            r_en = (k <= 40); r_addr = 6'(k); w_en = (k <= 40);
            w_addr = 6'd0; w_data = 32'hFFFF_FFFF; w_mask = 4'hF;
            @(posedge clock);
            #1;
            chk("sweep_a_busy", 32'(a_busy), 32'(k < 48));
            chk("sweep_b_busy", 32'(b_busy), 32'(k < 64));
            chk("sweep_a_valid", 32'(a_valid), 32'h0);
            chk("sweep_b_valid", 32'(b_valid), 32'h0);
            if (k == stop_at) return;
            @(negedge clock);
        end
        r_en = 1'b0; w_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ma[i] = 32'h0;
            mb[i] = 32'h0;
        end
        sb_restart();
    endtask
`endif

    initial begin
        n_cmp = 0; n_bad = 0; step_no = 0;
        reset_n = 1'b0;
        r_en = 1'b0; r_addr = '0; w_en = 1'b0; w_addr = '0; w_data = '0; w_mask = '0;
        for (int i = 0; i < 64; i++) begin
            ma[i] = 32'h0;
            mb[i] = 32'h0;
        end

        tbl[0]  = mkv(0, 6'd5,  1, 6'd5,  32'hDEADBEEF, 4'hF, 32'h0,        32'h0);
        tbl[1]  = mkv(1, 6'd5,  0, 6'd0,  32'h0,        4'h0, 32'hDEADBEEF, 32'hDEADBEEF);
        tbl[2]  = mkv(0, 6'd0,  1, 6'd3,  32'h11223344, 4'hF, 32'h0,        32'h0);
        tbl[3]  = mkv(0, 6'd0,  1, 6'd3,  32'hAABBCCDD, 4'h5, 32'h0,        32'h0);
        tbl[4]  = mkv(1, 6'd3,  0, 6'd0,  32'h0,        4'h0, 32'h11BB33DD, 32'h11BB33DD);
        tbl[5]  = mkv(1, 6'd7,  1, 6'd7,  32'hFFFFFFFF, 4'h3, 32'h0000FFFF, 32'h00000000);
        tbl[6]  = mkv(1, 6'd7,  0, 6'd0,  32'h0,        4'h0, 32'h0000FFFF, 32'h0000FFFF);
        tbl[7]  = mkv(0, 6'd0,  1, 6'd50, 32'h12345678, 4'hF, 32'h0,        32'h0);
        tbl[8]  = mkv(1, 6'd50, 0, 6'd0,  32'h0,        4'h0, 32'h0,        32'h12345678);
        tbl[9]  = mkv(1, 6'd18, 0, 6'd0,  32'h0,        4'h0, 32'h0,        32'h0);
        tbl[10] = mkv(1, 6'd50, 1, 6'd50, 32'hFFFFFFFF, 4'hF, 32'h0,        32'h12345678);
        tbl[11] = mkv(1, 6'd50, 0, 6'd0,  32'h0,        4'h0, 32'h0,        32'hFFFFFFFF);
        tbl[12] = mkv(0, 6'd0,  1, 6'd5,  32'h0,        4'h0, 32'h0,        32'h0);
        tbl[13] = mkv(1, 6'd5,  0, 6'd0,  32'h0,        4'h0, 32'hDEADBEEF, 32'hDEADBEEF);
        tbl[14] = mkv(0, 6'd0,  0, 6'd0,  32'h0,        4'h0, 32'h0,        32'h0);
        tbl[15] = mkv(0, 6'd0,  1, 6'd47, 32'hCAFEF00D, 4'hF, 32'h0,        32'h0);
        tbl[16] = mkv(1, 6'd47, 0, 6'd0,  32'h0,        4'h0, 32'hCAFEF00D, 32'hCAFEF00D);
        tbl[17] = mkv(0, 6'd0,  1, 6'd48, 32'h0BADC0DE, 4'hF, 32'h0,        32'h0);
        tbl[18] = mkv(1, 6'd48, 0, 6'd0,  32'h0,        4'h0, 32'h0,        32'h0BADC0DE);
        tbl[19] = mkv(1, 6'd63, 0, 6'd0,  32'h0,        4'h0, 32'h0,        32'h0);
        tbl[20] = mkv(1, 6'd47, 1, 6'd46, 32'h11111111, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D);

        do_reset();

`ifdef RAM_CLEAR_ON_RESET_EN
        clear_sweep(20);
        do_reset();
        clear_sweep(0);
        for (int i = 0; i < 64; i++) step_m(1'b1, 6'(i), 1'b0, 6'd0, 32'h0, 4'h0);
`endif

        // Known contents everywhere before directed checks.
        for (int i = 0; i < 64; i++) step_m(1'b0, 6'd0, 1'b1, 6'(i), 32'h0, 4'hF);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].re, tbl[i].ra, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wm,
                 tbl[i].ea, tbl[i].eb);
        end

        // Back-to-back reads of a distinct pattern, then idle cycles.
        for (int i = 0; i < 16; i++)
            step_m(1'b0, 6'd0, 1'b1, 6'(i), 32'h5A000000 + 32'(i) * 32'h00010101, 4'hF);
        for (int i = 0; i < 16; i++) step_m(1'b1, 6'(i), 1'b0, 6'd0, 32'h0, 4'h0);
        repeat (3) step_m(1'b0, 6'd0, 1'b0, 6'd0, 32'h0, 4'h0);

        // Reset with reads in flight, then confirm normal operation resumes.
        step_m(1'b1, 6'd1, 1'b0, 6'd0, 32'h0, 4'h0);
        step_m(1'b1, 6'd2, 1'b0, 6'd0, 32'h0, 4'h0);
        do_reset();
`ifdef RAM_CLEAR_ON_RESET_EN
        clear_sweep(0);
`endif
        step_m(1'b0, 6'd0, 1'b1, 6'd9, 32'h600DF00D, 4'hF);
        step_m(1'b1, 6'd9, 1'b0, 6'd0, 32'h0, 4'h0);
        repeat (2) step_m(1'b0, 6'd0, 1'b0, 6'd0, 32'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
